// File: rtl/rf_wport_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_wport_arbiter_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 1 << REG_AW;

  typedef enum logic [0:0] {
    StNormal = 1'b0,
    StForce  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small count-based FIFO holding MDU results ({wa, wd}) awaiting the RF write port.
module rf_wb_fifo #(
  parameter int unsigned Width = 37,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(Depth));
  assign rdata = mem_q[rd_ptr_q];

  // Depth is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Arbitrates the single RF write port between WB and buffered MDU results, with a
// starvation-triggered forced drain and a pending-write scoreboard for decode hazards.
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int unsigned XLEN     = rf_wport_arbiter_pkg::XLEN,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_wa,
  input  logic [XLEN-1:0]   wb_wd,
  input  logic              mdu_issue,
  input  logic [REG_AW-1:0] mdu_rd,
  input  logic              mdu_valid,
  input  logic [REG_AW-1:0] mdu_wa,
  input  logic [XLEN-1:0]   mdu_wd,
  output logic              mdu_ready,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rdc,
  output logic              hazard,
  output logic              pipe_stall,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wa,
  output logic [XLEN-1:0]   rf_wd
);

  localparam int unsigned EntW  = REG_AW + XLEN;
  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);

  arb_state_e          state_q, state_d;
  logic [WaitW-1:0]    wait_q, wait_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;

  logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [EntW-1:0]   head;
  logic [REG_AW-1:0] head_wa;
  logic [XLEN-1:0]   head_wd;

  assign fifo_push = mdu_valid & ~fifo_full;
  assign mdu_ready = ~fifo_full;
  assign head_wa   = head[EntW-1 -: REG_AW];
  assign head_wd   = head[XLEN-1:0];

  rf_wb_fifo #(
    .Width (EntW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({mdu_wa, mdu_wd}),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StNormal;
      wait_q    <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      StNormal: begin
        if (fifo_empty || fifo_pop) begin
          wait_d = '0;
        end else if (wb_we) begin
          if (wait_q == WaitLast) begin
            state_d = StForce;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + WaitW'(1);
          end
        end
      end
      StForce: begin
        state_d = StNormal;
        wait_d  = '0;
      end
      default: state_d = StNormal;
    endcase
  end

  // Outputs are held at reset values while rst is asserted, even with WB requesting.
  always_comb begin
    fifo_pop   = 1'b0;
    pipe_stall = 1'b0;
    rf_we      = 1'b0;
    rf_wa      = '0;
    rf_wd      = '0;
    if (!rst) begin
      unique case (state_q)
        StNormal: begin
          if (wb_we) begin
            rf_we = 1'b1;
            rf_wa = wb_wa;
            rf_wd = wb_wd;
          end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            rf_we    = (head_wa != '0);
            rf_wa    = head_wa;
            rf_wd    = head_wd;
          end
        end
        StForce: begin
          pipe_stall = 1'b1;
          fifo_pop   = ~fifo_empty;
          rf_we      = ~fifo_empty & (head_wa != '0);
          rf_wa      = head_wa;
          rf_wd      = head_wd;
        end
        default: ;
      endcase
    end
  end

  // Set after clear so a same-cycle re-issue to the draining register stays pending.
  always_comb begin
    pending_d = pending_q;
    if (fifo_pop && head_wa != '0) pending_d[head_wa] = 1'b0;
    if (mdu_issue && mdu_rd != '0) pending_d[mdu_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  assign hazard = pending_q[rs1] | pending_q[rs2] | pending_q[rdc];

endmodule
